// File: rtl/cplx_int_dump_if.sv
// cplx_int_dump_if
// Sample and result bundle for the complex integrate-and-dump stage.
//
// Signals:
//   data_i_i, data_q_i : signed 18-bit I/Q products from the multiplier
//   valid_i            : sample qualifier (gaps allowed)
//   len_i              : block length, LEN_W bits (0 is treated as 1)
//   shift_i            : output right shift, clamped to 16
//   data_i_o, data_q_o : scaled, rounded, 18-bit block sums
//   valid_o            : one-cycle pulse per completed block
//   sat_o              : limiting flag, qualified by valid_o
//
// Modports:
//   master : the producer/consumer side (drives samples, receives results)
//   slave  : the integrate-and-dump block itself
interface cplx_int_dump_if #(
  parameter int LEN_W = 16
);
  logic signed [17:0] data_i_i;
  logic signed [17:0] data_q_i;
  logic               valid_i;
  logic [LEN_W-1:0]   len_i;
  logic [4:0]         shift_i;
  logic signed [17:0] data_i_o;
  logic signed [17:0] data_q_o;
  logic               valid_o;
  logic               sat_o;

  modport master (
    output data_i_i, data_q_i, valid_i, len_i, shift_i,
    input  data_i_o, data_q_o, valid_o, sat_o
  );

  modport slave (
    input  data_i_i, data_q_i, valid_i, len_i, shift_i,
    output data_i_o, data_q_o, valid_o, sat_o
  );
endinterface

// File: rtl/cplx_int_dump.sv
// cplx_int_dump
// Complex integrate-and-dump. Sums a programmable number of valid I/Q
// samples into wide accumulators, then scales the block sum by a
// programmable right shift with round-half-up, narrows it to 18 bits and
// emits it as a single-cycle pulse. Blocks may run back-to-back.
//
// Ports:
//   clk_i  : clock, all logic on the rising edge
//   srst_i : synchronous active-high reset
//   bus    : cplx_int_dump_if.slave (samples in, block results out)
//
// Parameters:
//   LEN_W : width of the block-length input
//   ACC_W : accumulator width (accumulators/rounding use ACC_W+1 bits)
//
// Configuration macro:
//   CPLX_INT_DUMP_SAT_EN : when defined, results outside the 18-bit signed
//                          range are limited and sat_o flags it; otherwise
//                          results wrap to 18 bits and sat_o is tied to 0.
module cplx_int_dump #(
  parameter int LEN_W = 16,
  parameter int ACC_W = 18 + LEN_W
) (
  input logic            clk_i,
  input logic            srst_i,
  cplx_int_dump_if.slave bus
);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  localparam logic signed [ACC_W:0] ONE = {{ACC_W{1'b0}}, 1'b1};

  state_t                state;
  logic signed [ACC_W:0] acc_i;
  logic signed [ACC_W:0] acc_q;
  logic [LEN_W-1:0]      cnt;
  logic [LEN_W-1:0]      len_lat;
  logic [4:0]            shift_lat;
  logic                  blk_done;

  logic                  dump_vld;
  logic signed [ACC_W:0] dump_i;
  logic signed [ACC_W:0] dump_q;
  logic [4:0]            dump_shift;

  logic                  out_vld;
  logic signed [17:0]    out_i;
  logic signed [17:0]    out_q;

  logic [LEN_W:0]        cnt_next;
  logic                  len_is_one;
  logic [4:0]            shift_eff;
  logic signed [ACC_W:0] samp_i;
  logic signed [ACC_W:0] samp_q;

  logic signed [ACC_W:0] r_i;
  logic signed [ACC_W:0] r_q;
  logic signed [17:0]    lim_i;
  logic signed [17:0]    lim_q;

  // Round half up: add 2^(s-1) before the arithmetic shift. The adder is
  // as wide as the accumulator, so the bias can never wrap the sum.
  function automatic logic signed [ACC_W:0] round_shift(
    input logic signed [ACC_W:0] sum,
    input logic [4:0]            s
  );
    logic signed [ACC_W:0] half;
    half = '0;
    if (s != 5'd0) begin
      half = ONE << (s - 5'd1);
    end
    return (sum + half) >>> s;
  endfunction

  always_comb begin
    cnt_next   = {1'b0, cnt} + {{LEN_W{1'b0}}, 1'b1};
    len_is_one = (bus.len_i == '0) || (bus.len_i == LEN_W'(1));
    shift_eff  = (bus.shift_i > 5'd16) ? 5'd16 : bus.shift_i;
    samp_i     = {{(ACC_W - 17){bus.data_i_i[17]}}, bus.data_i_i};
    samp_q     = {{(ACC_W - 17){bus.data_q_i[17]}}, bus.data_q_i};
  end

  // Accumulation FSM. The first sample of a block loads the accumulators
  // rather than adding, which frees them for a new block on the cycle right
  // after a dump. blk_done marks that the accumulators hold a finished sum
  // for exactly one cycle, during which stage 1 copies it out.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state     <= IDLE;
      acc_i     <= '0;
      acc_q     <= '0;
      cnt       <= '0;
      len_lat   <= '0;
      shift_lat <= '0;
      blk_done  <= 1'b0;
    end else begin
      blk_done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.valid_i) begin
            acc_i     <= samp_i;
            acc_q     <= samp_q;
            shift_lat <= shift_eff;
            if (len_is_one) begin
              blk_done <= 1'b1;
            end else begin
              len_lat <= bus.len_i;
              cnt     <= LEN_W'(1);
              state   <= RUN;
            end
          end
        end
        RUN: begin
          if (bus.valid_i) begin
            acc_i <= acc_i + samp_i;
            acc_q <= acc_q + samp_q;
            if (cnt_next == {1'b0, len_lat}) begin
              blk_done <= 1'b1;
              cnt      <= '0;
              state    <= IDLE;
            end else begin
              cnt <= cnt_next[LEN_W-1:0];
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef CPLX_INT_DUMP_SAT_EN
  logic ovf_i;
  logic ovf_q;
  logic sat_r;

  // Returns {limited, value}. The result fits in 18 bits only when every
  // bit from 17 upward equals the sign bit.
  function automatic logic [18:0] limit18(input logic signed [ACC_W:0] r);
    logic pos_ovf;
    logic neg_ovf;
    pos_ovf = !r[ACC_W] && (|r[ACC_W-1:17]);
    neg_ovf = r[ACC_W] && !(&r[ACC_W-1:17]);
    if (pos_ovf) begin
      return {1'b1, 18'h1FFFF};
    end else if (neg_ovf) begin
      return {1'b1, 18'h20000};
    end else begin
      return {1'b0, r[17:0]};
    end
  endfunction

  always_comb begin
    r_i            = round_shift(dump_i, dump_shift);
    r_q            = round_shift(dump_q, dump_shift);
    {ovf_i, lim_i} = limit18(r_i);
    {ovf_q, lim_q} = limit18(r_q);
  end

  assign bus.sat_o = sat_r;
`else
  logic unused_hi;

  always_comb begin
    r_i   = round_shift(dump_i, dump_shift);
    r_q   = round_shift(dump_q, dump_shift);
    lim_i = r_i[17:0];
    lim_q = r_q[17:0];
  end

  // Upper bits of the rounded sum are discarded by the wrap-around narrowing.
  assign unused_hi = ^{r_i[ACC_W:18], r_q[ACC_W:18]};
  assign bus.sat_o = 1'b0;
`endif

  // Stage 1 captures the finished sum with its shift; stage 2 registers the
  // rounded/narrowed result. Reset clears both, cancelling any dump in flight.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      dump_vld   <= 1'b0;
      dump_i     <= '0;
      dump_q     <= '0;
      dump_shift <= '0;
      out_vld    <= 1'b0;
      out_i      <= '0;
      out_q      <= '0;
`ifdef CPLX_INT_DUMP_SAT_EN
      sat_r      <= 1'b0;
`endif
    end else begin
      dump_vld <= blk_done;
      if (blk_done) begin
        dump_i     <= acc_i;
        dump_q     <= acc_q;
        dump_shift <= shift_lat;
      end
      out_vld <= dump_vld;
      if (dump_vld) begin
        out_i <= lim_i;
        out_q <= lim_q;
      end
`ifdef CPLX_INT_DUMP_SAT_EN
      sat_r <= dump_vld && (ovf_i || ovf_q);
`endif
    end
  end

  assign bus.data_i_o = out_i;
  assign bus.data_q_o = out_q;
  assign bus.valid_o  = out_vld;

endmodule
